// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and stall controller for the 5-stage RV32I core. Sits beside
// the ID, EX and MEM stages and drives the stall/flush enables of the PC and
// the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use
// hazards, taken branch/jump redirects and multi-cycle data-memory waits,
// detects data-memory timeouts and keeps saturating stall/flush counters.
//
// Parameters
//   TIMEOUT  maximum stalled cycles for one data-memory access (>= 2)
//   CNT_W    width of each performance counter
//
// Ports
//   clk, arst_n                 core clock, asynchronous active-low reset
//   id_rs1/id_rs2 (+_used)      sources read by the instruction in ID
//   ex_rd, ex_rf_en, ex_is_load destination info of the instruction in EX
//   ex_branch_taken             EX resolved a taken branch/jal/jalr
//   mem_req, mem_ready          MEM-stage access request / completion
//   cnt_clr                     synchronous clear of both counters
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//   ex_mem_stall, mem_wb_flush  pipeline register controls (combinational)
//   mem_err                     sticky memory-timeout error
//   cnt_stall, cnt_flush        saturating stall / flush cycle counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rf_en,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0] cntStall_q, cntStall_d;
    logic [CNT_W-1:0] cntFlush_q, cntFlush_d;

    logic memWait;
    logic loadUse;
    logic freeze;

    assign memWait = mem_req && !mem_ready;

    // A load in EX whose result the ID instruction needs cannot be forwarded
    // in time; x0 never creates a dependency.
    assign loadUse = ex_is_load && ex_rf_en && (ex_rd != 5'd0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

    // Once in ERR the pipeline stays frozen regardless of memory activity.
    assign freeze = (state_q == ERR) || memWait;

    // Next-state logic for the memory-wait tracker. wait_cnt holds the number
    // of stalled cycles already seen, so stalled cycle k sees wait_cnt = k-1
    // and the last permitted cycle is the one with wait_cnt = TIMEOUT-1.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            RUN: begin
                if (memWait) begin
                    state_d   = MEM_WAIT;
                    waitCnt_d = WCW'(1);
                end else begin
                    waitCnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + WCW'(1);
                    if (waitCnt_q == WAIT_LAST) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    // Stall/flush priority: freeze, then redirect, then load-use. A redirect
    // wins over load-use because the ID instruction is discarded anyway, and
    // the PC must not be held so it can load the branch target.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (arst_n) begin
            if (freeze) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (loadUse) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
    end

    assign mem_err = arst_n && (state_q == ERR);

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_comb begin
        cntStall_d = cntStall_q;
        cntFlush_d = cntFlush_q;
        if (cnt_clr) begin
            cntStall_d = '0;
            cntFlush_d = '0;
        end else begin
            if (pc_stall && (cntStall_q != {CNT_W{1'b1}})) begin
                cntStall_d = cntStall_q + CNT_W'(1);
            end
            if (if_id_flush && (cntFlush_q != {CNT_W{1'b1}})) begin
                cntFlush_d = cntFlush_q + CNT_W'(1);
            end
        end
    end

    assign cnt_stall = cntStall_q;
    assign cnt_flush = cntFlush_q;

    // State, wait counter and performance counters.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= RUN;
            waitCnt_q  <= '0;
            cntStall_q <= '0;
            cntFlush_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            cntStall_q <= cntStall_d;
            cntFlush_q <= cntFlush_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed-vector bench for hazard_ctrl. Two instances share every input:
// dutMw uses TIMEOUT=16/CNT_W=32, dutSm uses TIMEOUT=4/CNT_W=4 so that the
// timeout and counter saturation cases are reachable quickly. Control outputs
// are packed as {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
// id_ex_flush, ex_mem_stall, mem_wb_flush}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] RD   = 7'b0010100;
    localparam logic [6:0] FRZ  = 7'b1101011;

    logic       clk;
    logic       arst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_rf_en, ex_is_load;
    logic       ex_branch_taken, mem_req, mem_ready, cnt_clr;

    logic [6:0]  ctlMw, ctlSm;
    logic        memErrMw, memErrSm;
    logic [31:0] cntStallMw, cntFlushMw;
    logic [3:0]  cntStallSm, cntFlushSm;

    logic pcsMw, ifsMw, iffMw, idsMw, idfMw, emsMw, mwfMw;
    logic pcsSm, ifsSm, iffSm, idsSm, idfSm, emsSm, mwfSm;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expStallMw, expFlushMw;
    logic [3:0]  expStallSm, expFlushSm;

    hazard_ctrl #(.TIMEOUT(16), .CNT_W(32)) dutMw (
        .clk(clk), .arst_n(arst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_stall(pcsMw), .if_id_stall(ifsMw), .if_id_flush(iffMw),
        .id_ex_stall(idsMw), .id_ex_flush(idfMw),
        .ex_mem_stall(emsMw), .mem_wb_flush(mwfMw),
        .mem_err(memErrMw), .cnt_stall(cntStallMw), .cnt_flush(cntFlushMw)
    );

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dutSm (
        .clk(clk), .arst_n(arst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_stall(pcsSm), .if_id_stall(ifsSm), .if_id_flush(iffSm),
        .id_ex_stall(idsSm), .id_ex_flush(idfSm),
        .ex_mem_stall(emsSm), .mem_wb_flush(mwfSm),
        .mem_err(memErrSm), .cnt_stall(cntStallSm), .cnt_flush(cntFlushSm)
    );

    assign ctlMw = {pcsMw, ifsMw, iffMw, idsMw, idfMw, emsMw, mwfMw};
    assign ctlSm = {pcsSm, ifsSm, iffSm, idsSm, idfSm, emsSm, mwfSm};

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive the hazard-related inputs for the coming cycle.
    task automatic applyStimulus(input logic [4:0] rs1, input logic rs1Used,
                                 input logic [4:0] rs2, input logic rs2Used,
                                 input logic [4:0] rd, input logic rfEn,
                                 input logic isLoad, input logic br,
                                 input logic req, input logic rdy);
        id_rs1          = rs1;
        id_rs1_used     = rs1Used;
        id_rs2          = rs2;
        id_rs2_used     = rs2Used;
        ex_rd           = rd;
        ex_rf_en        = rfEn;
        ex_is_load      = isLoad;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
    endtask

    // Check the combinational controls of both instances for the current
    // inputs, advance one clock edge and check both counter pairs.
    task automatic checkCycle(input string tag, input logic [6:0] expMw,
                              input logic [6:0] expSm);
        #1;
        checkOutput({tag, ".ctlMw"}, {25'd0, ctlMw}, {25'd0, expMw});
        checkOutput({tag, ".ctlSm"}, {25'd0, ctlSm}, {25'd0, expSm});
        if (cnt_clr) begin
            expStallMw = '0;
            expFlushMw = '0;
            expStallSm = '0;
            expFlushSm = '0;
        end else begin
            if (expMw[6] && expStallMw != 32'hFFFF_FFFF) expStallMw = expStallMw + 1;
            if (expMw[4] && expFlushMw != 32'hFFFF_FFFF) expFlushMw = expFlushMw + 1;
            if (expSm[6] && expStallSm != 4'hF) expStallSm = expStallSm + 1;
            if (expSm[4] && expFlushSm != 4'hF) expFlushSm = expFlushSm + 1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".cntStallMw"}, cntStallMw, expStallMw);
        checkOutput({tag, ".cntFlushMw"}, cntFlushMw, expFlushMw);
        checkOutput({tag, ".cntStallSm"}, {28'd0, cntStallSm}, {28'd0, expStallSm});
        checkOutput({tag, ".cntFlushSm"}, {28'd0, cntFlushSm}, {28'd0, expFlushSm});
    endtask

    // Assert reset with the current inputs still applied, check that every
    // output drops at once, then release reset with idle inputs.
    task automatic doReset(input string tag);
        arst_n = 1'b0;
        #1;
        checkOutput({tag, ".ctlMw"}, {25'd0, ctlMw}, 32'd0);
        checkOutput({tag, ".ctlSm"}, {25'd0, ctlSm}, 32'd0);
        checkOutput({tag, ".errMw"}, {31'd0, memErrMw}, 32'd0);
        checkOutput({tag, ".errSm"}, {31'd0, memErrSm}, 32'd0);
        checkOutput({tag, ".cntStallMw"}, cntStallMw, 32'd0);
        checkOutput({tag, ".cntStallSm"}, {28'd0, cntStallSm}, 32'd0);
        expStallMw = '0;
        expFlushMw = '0;
        expStallSm = '0;
        expFlushSm = '0;
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        expStallMw = '0;
        expFlushMw = '0;
        expStallSm = '0;
        expFlushSm = '0;
        cnt_clr    = 1'b0;
        arst_n     = 1'b0;
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state, and controls forced low even with a live hazard.
        #2;
        checkOutput("rst.errMw", {31'd0, memErrMw}, 32'd0);
        checkOutput("rst.cntStallMw", cntStallMw, 32'd0);
        checkOutput("rst.cntFlushSm", {28'd0, cntFlushSm}, 32'd0);
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("rst.ctlMw", {25'd0, ctlMw}, 32'd0);
        checkOutput("rst.ctlSm", {25'd0, ctlSm}, 32'd0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use detection and its qualifiers.
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("luRs1", LU, LU);
        applyStimulus(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("luRdZero", NONE, NONE);
        applyStimulus(5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("luRs2", LU, LU);
        applyStimulus(5'd5, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("luUnused", NONE, NONE);
        applyStimulus(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("luNoRfEn", NONE, NONE);
        applyStimulus(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("luNoLoad", NONE, NONE);

        // Redirect wins over a simultaneous load-use.
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkCycle("redirLu", RD, RD);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("redir", RD, RD);

        // Freeze beats redirect; three wait cycles, accepted in the fourth.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkCycle("memW1", FRZ, FRZ);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("memW2", FRZ, FRZ);
        checkCycle("memW3", FRZ, FRZ);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCycle("memRdy", NONE, NONE);

        // Back-to-back access; the small instance only survives if the
        // count restarted at 1, since ready comes in stalled cycle 4.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("b2bW1", FRZ, FRZ);
        checkCycle("b2bW2", FRZ, FRZ);
        checkCycle("b2bW3", FRZ, FRZ);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCycle("b2bRdy", NONE, NONE);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("idle", NONE, NONE);
        checkOutput("memOk.errMw", {31'd0, memErrMw}, 32'd0);
        checkOutput("memOk.errSm", {31'd0, memErrSm}, 32'd0);

        // Timeout on the small instance: frozen for cycles 1..4, error in 5.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("tmoW1", FRZ, FRZ);
        checkCycle("tmoW2", FRZ, FRZ);
        checkCycle("tmoW3", FRZ, FRZ);
        checkOutput("tmo3.errSm", {31'd0, memErrSm}, 32'd0);
        checkCycle("tmoW4", FRZ, FRZ);
        checkOutput("tmo5.errSm", {31'd0, memErrSm}, 32'd1);
        checkOutput("tmo5.errMw", {31'd0, memErrMw}, 32'd0);
        checkCycle("tmoW5", FRZ, FRZ);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCycle("tmoLateRdy", NONE, FRZ);
        checkOutput("tmoLate.errSm", {31'd0, memErrSm}, 32'd1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("tmoIdle", NONE, FRZ);
        checkOutput("tmoIdle.errSm", {31'd0, memErrSm}, 32'd1);
        doReset("tmoRst");
        checkOutput("tmoPost.errSm", {31'd0, memErrSm}, 32'd0);

        // Reset in MEM_WAIT with wait_cnt = 3.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkCycle("rmwW1", FRZ, FRZ);
        checkCycle("rmwW2", FRZ, FRZ);
        checkCycle("rmwW3", FRZ, FRZ);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doReset("rmwRst");
        checkCycle("rmwIdle", NONE, NONE);
        // A full-length access afterwards proves wait_cnt restarted from 0.
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) checkCycle("rmwAcc", FRZ, FRZ);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkCycle("rmwRdy", NONE, NONE);
        checkOutput("rmw.errSm", {31'd0, memErrSm}, 32'd0);

        // Saturation of the 4-bit stall counter, then clear beats increment.
        doReset("satRst");
        applyStimulus(5'd9, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) checkCycle("satLu", LU, LU);
        checkOutput("sat.cntStallSm", {28'd0, cntStallSm}, 32'd15);
        checkOutput("sat.cntStallMw", cntStallMw, 32'd20);
        cnt_clr = 1'b1;
        checkCycle("clrLu", LU, LU);
        checkOutput("clr.cntStallSm", {28'd0, cntStallSm}, 32'd0);
        cnt_clr = 1'b0;
        checkCycle("postClr", LU, LU);
        checkOutput("postClr.cntStallSm", {28'd0, cntStallSm}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
